// File: rtl/seg7_pkg.sv
// Shared constants, types and small helpers for the multiplexed
// seven-segment display driver.
package seg7_pkg;

    localparam int N_DIGITS = 4;

    typedef logic [7:0] seg_pattern_t;
    typedef logic [3:0] digit_sel_t;

    localparam seg_pattern_t SEG_OFF = 8'hFF;
    localparam digit_sel_t   DIG_OFF = 4'hF;

    function automatic digit_sel_t digit_onehot(input logic [1:0] idx);
        digit_onehot = digit_sel_t'(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// Digit slot timer: counts cycles within a slot, steps the digit index on
// each wrap, and flags the blanking window and the frame boundary cycle.
module seg7_slot_timer #(
    parameter int DIGIT_PERIOD = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    output logic [1:0] idx_o,
    output logic       blank_o,
    output logic       boundary_o
);

    localparam int CW = $clog2(DIGIT_PERIOD);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_PERIOD - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    if (DIGIT_PERIOD < 2) begin : g_bad_period
        $error("seg7_slot_timer: DIGIT_PERIOD must be at least 2");
    end
    if ((BLANK_CYCLES < 0) || (BLANK_CYCLES >= DIGIT_PERIOD)) begin : g_bad_blank
        $error("seg7_slot_timer: BLANK_CYCLES must satisfy 0 <= BLANK_CYCLES < DIGIT_PERIOD");
    end

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [1:0]    idx_q;
    logic [1:0]    idx_d;
    logic          wrap_s;

    assign wrap_s = (cnt_q == CNT_LAST);

    // Next slot position: advance the count, move to the next digit on wrap.
    always_comb begin
        cnt_d = cnt_q + CNT_ONE;
        idx_d = idx_q;
        if (wrap_s) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end else begin
            idx_d = idx_q;
        end
    end

    // Slot position registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            idx_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    if (BLANK_CYCLES == 0) begin : g_no_blank
        assign blank_o = 1'b0;
    end else begin : g_blank
        localparam logic [CW-1:0] BLANK_LIMIT = CW'(BLANK_CYCLES);
        assign blank_o = (cnt_q < BLANK_LIMIT);
    end

    assign idx_o      = idx_q;
    assign boundary_o = wrap_s && (idx_q == 2'd3);

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit time-multiplexed seven-segment driver with a shadow/active
// double buffer that only swaps at frame boundaries, so frames never tear.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGIT_PERIOD = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        clk_50,
    input  logic        reset_n,
    input  logic        load,
    input  logic [31:0] seg_data,
    input  logic [3:0]  digit_mask,
    output logic [7:0]  seg,
    output logic [3:0]  dig,
    output logic        frame_start
);

    logic [1:0] idx_s;
    logic       blank_s;
    logic       boundary_s;

    seg7_slot_timer #(
        .DIGIT_PERIOD (DIGIT_PERIOD),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_slot_timer (
        .clk_i      (clk_50),
        .rst_ni     (reset_n),
        .idx_o      (idx_s),
        .blank_o    (blank_s),
        .boundary_o (boundary_s)
    );

    seg_pattern_t [N_DIGITS-1:0] shadow_data_q, shadow_data_d;
    seg_pattern_t [N_DIGITS-1:0] active_data_q, active_data_d;
    digit_sel_t                  shadow_mask_q, shadow_mask_d;
    digit_sel_t                  active_mask_q, active_mask_d;
    logic                        pending_q, pending_d;
    seg_pattern_t                seg_q, seg_d;
    digit_sel_t                  dig_q, dig_d;
    logic                        frame_start_q, frame_start_d;

    // Buffer management: loads land in the shadow; a boundary promotes the
    // shadow, or the incoming word directly when a load coincides with it.
    always_comb begin
        shadow_data_d = shadow_data_q;
        shadow_mask_d = shadow_mask_q;
        active_data_d = active_data_q;
        active_mask_d = active_mask_q;
        pending_d     = pending_q;
        if (load) begin
            shadow_data_d = seg_data;
            shadow_mask_d = digit_mask;
        end else begin
            shadow_data_d = shadow_data_q;
        end
        if (boundary_s) begin
            pending_d = 1'b0;
            if (load) begin
                active_data_d = seg_data;
                active_mask_d = digit_mask;
            end else if (pending_q) begin
                active_data_d = shadow_data_q;
                active_mask_d = shadow_mask_q;
            end else begin
                active_data_d = active_data_q;
            end
        end else if (load) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end
    end

    // Next output values; masked digits keep their select off but still
    // drive the segment pattern so slot timing is mask-independent.
    always_comb begin
        seg_d         = SEG_OFF;
        dig_d         = DIG_OFF;
        frame_start_d = boundary_s;
        if (blank_s) begin
            seg_d = SEG_OFF;
            dig_d = DIG_OFF;
        end else begin
            seg_d = ~active_data_q[idx_s];
            dig_d = ~(digit_onehot(idx_s) & active_mask_q);
        end
    end

    // Buffer and output registers.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            shadow_data_q <= '0;
            shadow_mask_q <= 4'h0;
            active_data_q <= '0;
            active_mask_q <= 4'h0;
            pending_q     <= 1'b0;
            seg_q         <= SEG_OFF;
            dig_q         <= DIG_OFF;
            frame_start_q <= 1'b0;
        end else begin
            shadow_data_q <= shadow_data_d;
            shadow_mask_q <= shadow_mask_d;
            active_data_q <= active_data_d;
            active_mask_q <= active_mask_d;
            pending_q     <= pending_d;
            seg_q         <= seg_d;
            dig_q         <= dig_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign seg         = seg_q;
    assign dig         = dig_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (DIGIT_PERIOD = 8, BLANK_CYCLES = 2)
// against a frame/slot arithmetic reference model.
module tb_seg7_scan_driver;

    localparam int PERIOD = 8;
    localparam int BLANK  = 2;
    localparam int FRAME  = 4 * PERIOD;

    logic        clk_50 = 1'b0;
    logic        reset_n;
    logic        load;
    logic [31:0] seg_data;
    logic [3:0]  digit_mask;
    logic [7:0]  seg;
    logic [3:0]  dig;
    logic        frame_start;

    always #5 clk_50 = ~clk_50;

    seg7_scan_driver #(
        .DIGIT_PERIOD (PERIOD),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk_50      (clk_50),
        .reset_n     (reset_n),
        .load        (load),
        .seg_data    (seg_data),
        .digit_mask  (digit_mask),
        .seg         (seg),
        .dig         (dig),
        .frame_start (frame_start)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: k = rising edges since reset release.
    int         k;
    logic [7:0] act [4];
    logic [7:0] shd [4];
    logic [3:0] act_m;
    logic [3:0] shd_m;
    bit         pend;
    logic [7:0] exp_seg;
    logic [3:0] exp_dig;
    logic       exp_fs;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (edge %0d, t=%0t)", tag, obs, expv, k, $time);
        end
    endtask

    task automatic model_clear();
        k = 0;
        for (int j = 0; j < 4; j++) begin
            act[j] = 8'h00;
            shd[j] = 8'h00;
        end
        act_m   = 4'h0;
        shd_m   = 4'h0;
        pend    = 1'b0;
        exp_seg = 8'hFF;
        exp_dig = 4'hF;
        exp_fs  = 1'b0;
    endtask

    // Called at a falling edge: check outputs, drive inputs for the next
    // rising edge, predict what that edge produces, then advance.
    task automatic step(input bit ld, input logic [31:0] d, input logic [3:0] m);
        int  slot_cyc;
        int  digit;
        bit  bnd;
        check_value("seg", {24'h0, seg}, {24'h0, exp_seg});
        check_value("dig", {28'h0, dig}, {28'h0, exp_dig});
        check_value("frame_start", {31'h0, frame_start}, {31'h0, exp_fs});
        load       = ld;
        seg_data   = d;
        digit_mask = m;
        slot_cyc = k % PERIOD;
        digit    = (k / PERIOD) % 4;
        bnd      = ((k % FRAME) == FRAME - 1);
        if (slot_cyc < BLANK) begin
            exp_seg = 8'hFF;
            exp_dig = 4'hF;
        end else begin
            exp_seg = ~act[digit];
            exp_dig = 4'hF;
            if (act_m[digit]) exp_dig[digit] = 1'b0;
        end
        exp_fs = bnd;
        if (ld) begin
            for (int j = 0; j < 4; j++) shd[j] = d[8*j +: 8];
            shd_m = m;
        end
        if (bnd) begin
            if (ld || pend) begin
                act   = shd;
                act_m = shd_m;
            end
            pend = 1'b0;
        end else if (ld) begin
            pend = 1'b1;
        end
        k++;
        @(negedge clk_50);
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(1'b0, $urandom, 4'($urandom));
    endtask

    task automatic run_to(input int phase);
        for (int j = 0; j < FRAME && (k % FRAME) != phase; j++) step(1'b0, $urandom, 4'($urandom));
    endtask

    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        load    = 1'b0;
        #1;
        check_value("rst_seg", {24'h0, seg}, 32'h0000_00FF);
        check_value("rst_dig", {28'h0, dig}, 32'h0000_000F);
        check_value("rst_fs", {31'h0, frame_start}, 32'h0);
        @(negedge clk_50);
        @(negedge clk_50);
        model_clear();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n    = 1'b0;
        load       = 1'b0;
        seg_data   = 32'h0;
        digit_mask = 4'h0;
        model_clear();
        @(negedge clk_50);
        @(negedge clk_50);
        check_value("init_seg", {24'h0, seg}, 32'h0000_00FF);
        check_value("init_dig", {28'h0, dig}, 32'h0000_000F);
        reset_n = 1'b1;

        // Release with no load: blank display, frame pulse after 32 cycles.
        idle(2 * FRAME + 3);

        // Mid-frame load, all digits enabled.
        do_reset();
        idle(5);
        step(1'b1, 32'h7E306D79, 4'hF);
        idle(2 * FRAME);

        // Partial mask.
        run_to(10);
        step(1'b1, $urandom, 4'b0101);
        idle(2 * FRAME);

        // Last load in a frame wins.
        run_to(3);
        step(1'b1, 32'hA1A2A3A4, 4'hF);
        idle(7);
        step(1'b1, 32'hB1B2B3B4, 4'b1011);
        idle(2 * FRAME);

        // Load exactly on the boundary cycle bypasses the shadow.
        run_to(FRAME - 1);
        step(1'b1, 32'h3F065B4F, 4'b1110);
        idle(2 * FRAME + 2);

        // Reset at slot cycle 4 of digit 2.
        run_to(2 * PERIOD + 4);
        do_reset();
        idle(FRAME + 4);

        // Random traffic, including loads landing on boundaries.
        for (int n = 0; n < 900; n++) begin
            if ($urandom_range(0, 11) == 0) step(1'b1, $urandom, 4'($urandom));
            else step(1'b0, $urandom, 4'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
